// File: rtl/dmux16_collect.sv
// dmux16_collect: serial-to-parallel collector.
// One bit per accepted beat is steered into one of 16 slots, chosen by an
// explicit select (auto=0) or by an internal auto-incrementing pointer
// (auto=1). Once every slot has been written at least once since the last
// completion or reset, the assembled word is snapshotted into `word` and
// `done` pulses for one cycle.
//
// Handshake: `in_valid` is a plain beat qualifier with no ready/backpressure.
// A beat is any rising edge with in_valid=1 and reset=0; in, sel and auto
// are sampled only on beats. One beat per cycle is always accepted.
module dmux16_collect (
  input  logic        clk,
  input  logic        reset,
  input  logic        in,
  input  logic        in_valid,
  input  logic [3:0]  sel,
  input  logic        auto,
  output logic [15:0] out,
  output logic [15:0] word,
  output logic [3:0]  ptr,
  output logic        done
);

  logic [15:0] r_out;
  logic [15:0] r_mask;   // slots written since last completion/reset
  logic [3:0]  r_ptr;
  logic [15:0] r_word;
  logic        r_done;

  logic [3:0]  w_slot;
  logic [15:0] w_out_next;
  logic [15:0] w_mask_next;
  logic        w_complete;

  // Slot selection and next-state candidates for the current beat.
  always_comb begin
    w_slot              = auto ? r_ptr : sel;
    w_out_next          = r_out;
    w_out_next[w_slot]  = in;
    w_mask_next         = r_mask | (16'h0001 << w_slot);
    w_complete          = in_valid && (w_mask_next == 16'hFFFF);
  end

  // State update: reset wins over a concurrent beat; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= 16'h0000;
      r_mask <= 16'h0000;
      r_ptr  <= 4'd0;
      r_word <= 16'h0000;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (in_valid) begin
        r_out <= w_out_next;
        if (auto) begin
          r_ptr <= r_ptr + 4'd1;
        end
        if (w_complete) begin
          // Snapshot includes the bit written by this beat.
          r_word <= w_out_next;
          r_mask <= 16'h0000;
          r_done <= 1'b1;
        end else begin
          r_mask <= w_mask_next;
        end
      end
    end
  end

  assign out  = r_out;
  assign word = r_word;
  assign ptr  = r_ptr;
  assign done = r_done;

endmodule

// File: tb/tb_dmux16_collect.sv
// Testbench for dmux16_collect: directed beats, expected words queued at the
// completing beat and checked by an independent done monitor.
module tb_dmux16_collect;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        auto = 1'b0;
  logic [15:0] out;
  logic [15:0] word;
  logic [3:0]  ptr;
  logic        done;

  always #5 clk = ~clk;

  dmux16_collect dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .sel      (sel),
    .auto     (auto),
    .out      (out),
    .word     (word),
    .ptr      (ptr),
    .done     (done)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] exp_out = 16'h0000;
  logic [3:0]  exp_ptr = 4'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      logic [15:0] w;
      n_done++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got done=1 word=%h expected no done at %0t", word, $time);
      end else begin
        w = exp_q.pop_front();
        if (word !== w) begin
          n_err++;
          $display("FAIL word: got %h expected %h at %0t", word, w, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One beat; push_w=1 marks the beat that must complete a word equal to w.
  task automatic beat(input logic a, input logic [3:0] s, input logic b,
                      input logic push_w, input logic [15:0] w);
    logic [3:0] slot;
    in_valid = 1'b1; auto = a; sel = s; in = b;
    slot = a ? exp_ptr : s;
    exp_out[slot] = b;
    if (a) exp_ptr = exp_ptr + 4'd1;
    if (push_w) exp_q.push_back(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    auto = 1'($urandom_range(0, 1));
    sel  = 4'($urandom_range(0, 15));
    in   = 1'($urandom_range(0, 1));
    chk16("out", out, exp_out);
    chk16("ptr", {12'h000, ptr}, {12'h000, exp_ptr});
    chk16("done", {15'h0000, done}, {15'h0000, push_w});
  endtask

  // Idle cycles with junk on the ignored inputs; state must hold.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      auto = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      in   = 1'($urandom_range(0, 1));
    end
    chk16("idle_out", out, exp_out);
    chk16("idle_ptr", {12'h000, ptr}, {12'h000, exp_ptr});
    chk16("idle_done", {15'h0000, done}, 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with live, random beats present.
    reset = 1'b1;
    repeat (2) begin
      in_valid = 1'b1;
      auto = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      in   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk16("rst_out", out, 16'h0000);
    chk16("rst_word", word, 16'h0000);
    chk16("rst_ptr", {12'h000, ptr}, 16'h0000);
    chk16("rst_done", {15'h0000, done}, 16'h0000);
    reset = 1'b0;
    in_valid = 1'b0;
    idle(1);

    // Auto fill: 1 on even beats, 0 on odd beats -> 16'h5555.
    for (int i = 0; i < 16; i++)
      beat(1'b1, 4'd0, (i % 2 == 0), (i == 15), 16'h5555);
    chk16("auto_word", word, 16'h5555);
    for (int i = 0; i < 16; i++)
      chk16("auto_mux16", {15'h0000, word[i]}, {15'h0000, (i % 2 == 0)});
    idle(2);

    // Addressed fill in reverse order; only slots 15 and 0 get a 1.
    for (int i = 15; i >= 0; i--)
      beat(1'b0, 4'(i), (i == 15 || i == 0), (i == 0), 16'h8001);
    chk16("rev_word", word, 16'h8001);
    chk16("rev_ptr", {12'h000, ptr}, 16'h0000);
    idle(1);

    // Duplicate/gap: slots 0..14 get slot[0], slot 3 rewritten to 0, then slot 15=1.
    for (int i = 0; i < 15; i++)
      beat(1'b0, 4'(i), 1'(i % 2), 1'b0, 16'h0000);
    beat(1'b0, 4'd3, 1'b0, 1'b0, 16'h0000);
    chk16("dup_out3", {15'h0000, out[3]}, 16'h0000);
    beat(1'b0, 4'd15, 1'b1, 1'b1, 16'hAAA2);
    chk16("dup_word", word, 16'hAAA2);
    idle(1);

    // Reset mid-word: partial word discarded, no done.
    for (int i = 0; i < 8; i++)
      beat(1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_out = 16'h0000;
    exp_ptr = 4'd0;
    chk16("mid_rst_out", out, 16'h0000);
    chk16("mid_rst_word", word, 16'h0000);
    chk16("mid_rst_ptr", {12'h000, ptr}, 16'h0000);
    for (int i = 0; i < 16; i++)
      beat(1'b1, 4'd0, 1'b1, (i == 15), 16'hFFFF);
    chk16("post_rst_word", word, 16'hFFFF);

    // Mixed modes with idle gaps: auto covers 0..7, sel covers 8..15.
    // Ones only in slots 2, 8, 15 -> 16'h8104.
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 4'd0, (i == 2), 1'b0, 16'h0000);
      idle($urandom_range(1, 3));
      beat(1'b0, 4'(8 + i), (i == 0 || i == 7), (i == 7), 16'h8104);
      idle($urandom_range(1, 3));
    end
    chk16("mix_word", word, 16'h8104);
    chk16("mix_ptr", {12'h000, ptr}, 16'h0008);
    idle(3);

    // Final accounting.
    chk16("done_count", 16'(n_done), 16'd5);
    chk16("exp_q_left", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmux16_collect.md
# dmux16_collect

Sequential 1-to-16 demultiplexer and collector: the write-side counterpart of the `mux16` 16:1 selector. It routes one serial input bit per accepted beat into one of 16 register slots. The slot is chosen either by an explicit 4-bit select or by an internal auto-incrementing pointer. When all 16 slots have been written, it publishes the assembled word with a one-cycle completion pulse. It sits in front of `mux16`-style readers, so a word scanned out bit-by-bit through `mux16` can be reassembled in the other direction.

## Interface
Parameters: none; widths are fixed at 16 slots / 4-bit select.

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in` input 1: data bit to store.
- `in_valid` input 1: beat qualifier; `in`, `sel` and `auto` are ignored when low.
- `sel` input 4: target slot in addressed mode.
- `auto` input 1: 0 selects addressed mode (slot = `sel`); 1 selects auto mode (slot = `ptr`). Sampled per beat.
- `out` output 16: live slot register; bit i = last value written to slot i.
- `word` output 16: snapshot of the last completed word.
- `ptr` output 4: auto-mode write pointer.
- `done` output 1: one-cycle pulse; the word is complete and `word` is updated.

## Operation
- Internal state: `out[15:0]`, `mask[15:0]` (slot-written flags), `ptr[3:0]`, `word[15:0]`, `done`.
- Reset (`reset`=1 at an edge): `out`=0, `mask`=0, `ptr`=0, `word`=0, `done`=0. Reset has priority over any concurrent beat. Reset mid-word discards the partial word, and no `done` pulse is issued.
- Beat = edge with `in_valid`=1 and `reset`=0.
  - Slot s is `sel` if `auto`=0, else `ptr`.
  - `out[s]` <= `in`; all other `out` bits hold.
  - `mask[s]` <= 1.
  - If `auto`=1: `ptr` <= `ptr`+1 mod 16 (15 wraps to 0). If `auto`=0: `ptr` holds.
- Completion: let next_mask = `mask` | (1<<s). If next_mask == 16'hFFFF at a beat:
  - `word` <= next value of `out`, which includes the bit just written.
  - `mask` <= 0.
  - `done` <= 1.
- `done` <= 0 at every other edge, so it is never high for two consecutive cycles unless two completions occur on consecutive beats. Consecutive completions are impossible, because 16 beats are needed per word.
- Re-writing an already-written slot overwrites `out[s]`. `mask` is unchanged and there is no completion progress.
- `out` is not cleared on completion. Slots retain old values until rewritten.
- Modes may be mixed within one word. Completion depends only on `mask`.
- No beat: all state holds except `done`, which returns to 0.

## Timing
- All outputs are registered. A beat's effect is visible on `out`, `ptr` and `mask` the cycle after the sampling edge.
- `done` and the new `word` value appear together, one cycle after the completing beat's edge. `done` is high for exactly one cycle. `word` holds until the next completion or reset.
- Throughput: one beat per cycle; no backpressure; `in_valid` may be held high continuously.
- Minimum completion latency: 16 consecutive beats; `done` is high in cycle 17 counted from the first beat's edge.
- Combinational paths from inputs to outputs: none.

## Test plan
- Reset: drive random inputs with `reset`=1 for 2 cycles, including `in_valid`=1. Required: `out`=0, `word`=0, `ptr`=0, `done`=0.
- Auto fill: `auto`=1, 16 consecutive beats with `in` = 1 on even beats and 0 on odd beats (beats 0..15). Required:
  - `ptr` steps 1..15 then 0.
  - `done` pulses once, the cycle after beat 15.
  - `word`=16'h5555 and `out`=16'h5555.
  - `mux16` with `sel`=0..15 on `word` reproduces 1,0,1,0,….
- Addressed fill, reverse order: `auto`=0, `sel`=15 down to 0, `in`=1 only for `sel`=15 and `sel`=0. Required: `ptr` stays 0; `done` one cycle after the `sel`=0 beat; `word`=16'h8001.
- Duplicate/gap: addressed beats to slots 0..14, then slot 3 again with `in` flipped. Required: no `done`, and `out[3]` updated. Then a beat to slot 15. Required: `done` pulse, and `word` reflects the flipped bit 3.
- Reset mid-word: 8 auto beats, `reset` for 1 cycle, then 16 auto beats of `in`=1. Required: no `done` before the 16th post-reset beat; then `done`=1 and `word`=16'hFFFF.
- Idle gaps and mode mix: 16 beats interleaving `auto`=1 and `auto`=0 (with `sel` covering the slots `ptr` skips), with `in_valid` low for 1–3 cycles between beats. Required: state holds during gaps; exactly one `done`, after the 16th distinct slot is written.
